color_scan_controller: RTL and testbench

- Sequences a TCS3200-style colour sensor through its red, blue and green filters.
- For each filter it waits a settle time, then counts sensor output edges over a fixed gate window.
- After the three channels it classifies the dominant colour and publishes the counts and the colour code.
- Sits between the sensor pins (scale, filter, enable, frequency input) and the rover navigation logic.

---
 rtl/color_scan_if.sv | 29 ++
 rtl/color_scan_controller.sv | 170 +++++++++++++++++
 tb/tb_color_scan_controller.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/color_scan_if.sv
// Colour-scan controller signal bundle: request/config from the navigation side,
// sensor pins and published results from the controller.
interface color_scan_if #(
    parameter int CNT_W = 20
);
    logic             start;
    logic             continuous;
    logic             sensor_freq;
    logic [1:0]       scale;
    logic [1:0]       filter;
    logic             enf;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] blue_cnt;
    logic [CNT_W-1:0] green_cnt;
    logic [2:0]       color;
    logic             overflow;

    modport master (
        output start, continuous, sensor_freq,
        input  scale, filter, enf, busy, done, red_cnt, blue_cnt, green_cnt, color, overflow
    );

    modport slave (
        input  start, continuous, sensor_freq,
        output scale, filter, enf, busy, done, red_cnt, blue_cnt, green_cnt, color, overflow
    );
endinterface

// File: rtl/color_scan_controller.sv
// Steps a TCS3200-style sensor through red/blue/green filters, counts output edges
// per gate window and publishes the counts plus the dominant colour.
module color_scan_controller #(
    parameter int         GATE_CYCLES   = 1000000,
    parameter int         SETTLE_CYCLES = 10000,
    parameter int         CNT_W         = 20,
    parameter int         MARGIN        = 16,
    parameter int         MIN_COUNT     = 32,
    parameter logic [1:0] SCALE         = 2'b11
) (
    input logic       clk,
    input logic       rst,
    color_scan_if.slave bus
);
    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W:0]   MARGIN_X    = (CNT_W+1)'(MARGIN);
    localparam logic [CNT_W:0]   MIN_X       = (CNT_W+1)'(MIN_COUNT);

    typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DECIDE} state_t;
    typedef enum logic [1:0] {CH_RED, CH_BLUE, CH_GREEN} chan_t;

    state_t           state;
    chan_t            ch;
    logic [TW-1:0]    timer;
    logic [CNT_W-1:0] work, work_nxt;
    logic             clip, ovf_work;
    logic [CNT_W-1:0] red_h, blue_h, green_h;
    logic [2:0]       color_nxt;

    // [0],[1] synchronise the async input, [2] holds the previous synchronised value
    logic [2:0] freq_pipe;
    logic       rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) freq_pipe <= '0;
        else     freq_pipe <= {freq_pipe[1:0], bus.sensor_freq};
    end

    assign rise = freq_pipe[1] & ~freq_pipe[2];

    // Saturating edge counter; a clipped edge marks the scan as overflowed
    always_comb begin
        work_nxt = work;
        clip     = 1'b0;
        if (state == COUNT && rise) begin
            if (work == CNT_MAX) clip = 1'b1;
            else                 work_nxt = work + CNT_W'(1);
        end
    end

    function automatic logic wins(logic [CNT_W:0] m, logic [CNT_W:0] o1, logic [CNT_W:0] o2);
        return (m >= MIN_X) && (m > o1) && (m > o2) &&
               (m >= o1 + MARGIN_X) && (m >= o2 + MARGIN_X);
    endfunction

    always_comb begin
        logic [CNT_W:0] rx, bx, gx;
        rx = {1'b0, red_h};
        bx = {1'b0, blue_h};
        gx = {1'b0, green_h};
        color_nxt = 3'b000;
        if (wins(rx, bx, gx))      color_nxt = 3'b001;
        else if (wins(bx, rx, gx)) color_nxt = 3'b010;
        else if (wins(gx, rx, bx)) color_nxt = 3'b100;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            ch            <= CH_RED;
            timer         <= '0;
            work          <= '0;
            ovf_work      <= 1'b0;
            red_h         <= '0;
            blue_h        <= '0;
            green_h       <= '0;
            bus.scale     <= SCALE;
            bus.filter    <= 2'b00;
            bus.enf       <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.red_cnt   <= '0;
            bus.blue_cnt  <= '0;
            bus.green_cnt <= '0;
            bus.color     <= 3'b000;
            bus.overflow  <= 1'b0;
        end else begin
            bus.scale <= SCALE;
            bus.done  <= 1'b0;
            work      <= work_nxt;
            ovf_work  <= ovf_work | clip;
            case (state)
                IDLE: begin
                    bus.enf    <= 1'b0;
                    bus.filter <= 2'b00;
                    bus.busy   <= 1'b0;
                    if (bus.start) begin
                        state      <= SETTLE;
                        ch         <= CH_RED;
                        timer      <= '0;
                        work       <= '0;
                        ovf_work   <= 1'b0;
                        bus.enf    <= 1'b1;
                        bus.busy   <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (timer == SETTLE_LAST) begin
                        state <= COUNT;
                        timer <= '0;
                        work  <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                COUNT: begin
                    if (timer == GATE_LAST) begin
                        timer <= '0;
                        // work_nxt folds in an edge seen in the final gate cycle
                        case (ch)
                            CH_RED: begin
                                red_h      <= work_nxt;
                                ch         <= CH_BLUE;
                                bus.filter <= 2'b01;
                                state      <= SETTLE;
                            end
                            CH_BLUE: begin
                                blue_h     <= work_nxt;
                                ch         <= CH_GREEN;
                                bus.filter <= 2'b11;
                                state      <= SETTLE;
                            end
                            default: begin
                                green_h <= work_nxt;
                                state   <= DECIDE;
                            end
                        endcase
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DECIDE: begin
                    bus.red_cnt   <= red_h;
                    bus.blue_cnt  <= blue_h;
                    bus.green_cnt <= green_h;
                    bus.color     <= color_nxt;
                    bus.overflow  <= ovf_work;
                    bus.done      <= 1'b1;
                    bus.filter    <= 2'b00;
                    if (bus.continuous) begin
                        state    <= SETTLE;
                        ch       <= CH_RED;
                        timer    <= '0;
                        work     <= '0;
                        ovf_work <= 1'b0;
                    end else begin
                        state    <= IDLE;
                        bus.enf  <= 1'b0;
                        bus.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_color_scan_controller.sv
// Bench for color_scan_controller: periodic sensor waveforms per filter, expected
// counts from rise-per-window arithmetic and colour from the classification rules.
module tb_color_scan_controller;
    localparam int G  = 100;
    localparam int S  = 10;
    localparam int W  = 8;
    localparam int M  = 4;
    localparam int MN = 8;
    localparam int GB = 200;
    localparam int WB = 6;
    localparam int SCAN_LAT = 3 * (S + G) + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    color_scan_if #(.CNT_W(W))  a();
    color_scan_if #(.CNT_W(WB)) b();

    color_scan_controller #(
        .GATE_CYCLES(G), .SETTLE_CYCLES(S), .CNT_W(W), .MARGIN(M), .MIN_COUNT(MN), .SCALE(2'b11)
    ) dut (.clk(clk), .rst(rst), .bus(a.slave));

    color_scan_controller #(
        .GATE_CYCLES(GB), .SETTLE_CYCLES(S), .CNT_W(WB), .MARGIN(M), .MIN_COUNT(MN), .SCALE(2'b11)
    ) dut_sat (.clk(clk), .rst(rst), .bus(b.slave));

    int errs = 0, checks = 0;
    int cyc = 0;
    int pr = 4, pb = 20, pg = 20, cur = 0, ph = 0;
    int t_blue = -1, t_green = -1, t_start = 0, done_cnt = 0;
    logic [1:0] lastf = 2'b00;
    bit bf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Per-filter square wave for the main DUT, period-2 wave for the saturation DUT
    always @(negedge clk) begin
        int p;
        p = (a.filter == 2'b01) ? pb : (a.filter == 2'b11) ? pg : pr;
        if (a.filter != lastf) begin
            if (a.filter == 2'b01) t_blue = cyc;
            if (a.filter == 2'b11) t_green = cyc;
        end
        if (p != cur || a.filter != lastf) begin
            cur = p;
            ph  = 0;
        end else begin
            ph = (ph + 1) % cur;
        end
        lastf = a.filter;
        a.sensor_freq = (ph < cur / 2);
        bf = ~bf;
        b.sensor_freq = bf;
        if (a.done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] ref_color(input int r, input int bl, input int g);
        if (r >= MN && r >= bl + M && r >= g + M) return 3'b001;
        if (bl >= MN && bl >= r + M && bl >= g + M) return 3'b010;
        if (g >= MN && g >= r + M && g >= bl + M) return 3'b100;
        return 3'b000;
    endfunction

    task automatic pulse_start_a();
        @(negedge clk);
        a.start = 1'b1;
        t_start = cyc;
        @(negedge clk);
        a.start = 1'b0;
    endtask

    task automatic wait_done_a(input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (a.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("done_timeout", 0, 1);
    endtask

    task automatic scan_a(input int r, input int bl, input int g, output int lat);
        int at;
        pr = r; pb = bl; pg = g;
        repeat (2) @(negedge clk);
        pulse_start_a();
        wait_done_a(1200, at);
        lat = at - t_start;
        @(negedge clk);
        chk("done_one_cycle", a.done, 0);
    endtask

    task automatic chk_res(input int r, input int bl, input int g);
        chk("red_cnt", a.red_cnt, r);
        chk("blue_cnt", a.blue_cnt, bl);
        chk("green_cnt", a.green_cnt, g);
        chk("color", a.color, ref_color(r, bl, g));
        chk("overflow", a.overflow, 0);
    endtask

    initial begin
        int lat, t1, t2, s0, nd0, at;
        int ps[8];
        bit enf_low;
        ps = '{2, 4, 5, 10, 20, 25, 50, 100};
        a.start = 1'b0; a.continuous = 1'b0;
        b.start = 1'b0; b.continuous = 1'b0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("idle_enf", a.enf, 0);
        chk("idle_filter", a.filter, 0);
        chk("idle_busy", a.busy, 0);
        chk("idle_scale", a.scale, 3);
        chk("idle_color", a.color, 0);
        chk("idle_counts", {8'd0, a.red_cnt, a.blue_cnt, a.green_cnt}, 0);
        chk("idle_overflow", a.overflow, 0);
        chk("idle_no_done", done_cnt, 0);

        // Red dominant, latency and filter timing
        scan_a(4, 20, 20, lat);
        chk("latency", lat, SCAN_LAT);
        chk("filter_blue_edge", t_blue - t_start, S + G + 1);
        chk("filter_green_edge", t_green - t_start, 2 * (S + G) + 1);
        chk_res(25, 5, 5);
        chk("busy_after", a.busy, 0);
        chk("enf_after", a.enf, 0);

        // Tie, margin not met, below minimum
        scan_a(10, 10, 10, lat);
        chk_res(10, 10, 10);
        scan_a(10, 10, 8, lat);
        chk("p8_red", a.red_cnt, 10);
        chk("p8_green_range", (a.green_cnt == 12 || a.green_cnt == 13), 1);
        chk("p8_color", a.color, 0);
        scan_a(40, 40, 40, lat);
        chk("p40_range", (a.red_cnt >= 2 && a.red_cnt <= 3 && a.blue_cnt >= 2 &&
                          a.blue_cnt <= 3 && a.green_cnt >= 2 && a.green_cnt <= 3), 1);
        chk("p40_color", a.color, 0);

        // Random periods dividing the gate window give exact rise counts G/p
        for (int k = 0; k < 8; k++) begin
            int r, bl, g;
            r  = ps[$urandom_range(0, 7)];
            bl = ps[$urandom_range(0, 7)];
            g  = ps[$urandom_range(0, 7)];
            repeat ($urandom_range(0, 7)) @(negedge clk);
            scan_a(r, bl, g, lat);
            chk("rand_latency", lat, SCAN_LAT);
            chk_res(G / r, G / bl, G / g);
        end

        // Continuous: two back-to-back scans, a start during busy is ignored
        a.continuous = 1'b1;
        pr = 4; pb = 20; pg = 20;
        repeat (2) @(negedge clk);
        nd0 = done_cnt;
        pulse_start_a();
        s0 = t_start;
        wait_done_a(1200, t1);
        a.continuous = 1'b0;
        chk("cont_busy", a.busy, 1);
        chk("cont_enf", a.enf, 1);
        t2 = -1;
        enf_low = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            a.start = (i == 50);
            if (a.done === 1'b1) begin
                t2 = cyc;
                break;
            end
            if (a.enf !== 1'b1) enf_low = 1'b1;
        end
        a.start = 1'b0;
        chk("cont_period", t2 - t1, SCAN_LAT - 1);
        chk("cont_two_scans", t2 - (s0 + 1), 2 * (SCAN_LAT - 1));
        chk("cont_enf_held", enf_low, 0);
        repeat (400) @(negedge clk);
        chk("cont_stopped", a.busy, 0);
        chk("cont_done_count", done_cnt - nd0, 2);
        chk_res(25, 5, 5);

        // Reset in the middle of blue COUNT
        pulse_start_a();
        repeat (150) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", a.busy, 0);
        chk("rst_enf", a.enf, 0);
        chk("rst_filter", a.filter, 0);
        chk("rst_counts", {8'd0, a.red_cnt, a.blue_cnt, a.green_cnt}, 0);
        chk("rst_color", a.color, 0);
        @(negedge clk);
        rst = 1'b0;
        scan_a(20, 4, 20, lat);
        chk("post_rst_latency", lat, SCAN_LAT);
        chk_res(5, 25, 5);

        // Saturation on the narrow-counter instance
        chk("sat_ovf_reset", b.overflow, 0);
        @(negedge clk);
        b.start = 1'b1;
        @(negedge clk);
        b.start = 1'b0;
        at = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (b.done === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk("sat_done_seen", (at >= 0), 1);
        chk("sat_red", b.red_cnt, 63);
        chk("sat_blue", b.blue_cnt, 63);
        chk("sat_green", b.green_cnt, 63);
        chk("sat_overflow", b.overflow, 1);
        chk("sat_color", b.color, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
